// File: rtl/uio_arb_pkg.sv
// Shared types and constants for the uio pin arbiter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: FSM state enum, pin direction constants, width constants, one-hot helper.
package uio_arb_pkg;

  localparam int LEN_W = 4;
  localparam int PIN_W = 8;

  localparam logic DIR_IN  = 1'b0;  // requester samples the pins
  localparam logic DIR_OUT = 1'b1;  // requester drives the pins

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TURN = 2'd1,
    XFER = 2'd2
  } arb_state_t;

  // Requester index to 2-bit one-hot.
  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/uio_bus_arbiter_if.sv
// Bundle of requester handshake signals and uio pin signals around the arbiter.
// Latency: n/a (wires only).
// Backpressure: n/a; flow control is the req/gnt/last burst handshake.
// Ports: master = requesters + pad side (drives req/dir/len/wdata/uio_in),
//        slave  = arbiter (drives gnt/last/rdata/rvalid/uio_out/uio_oe).
interface uio_bus_arbiter_if;
  import uio_arb_pkg::*;

  logic             ena;
  logic [1:0]       req;
  logic [1:0]       dir;
  logic [LEN_W-1:0] len0;
  logic [LEN_W-1:0] len1;
  logic [PIN_W-1:0] wdata0;
  logic [PIN_W-1:0] wdata1;
  logic [1:0]       gnt;
  logic             last;
  logic [PIN_W-1:0] rdata;
  logic [1:0]       rvalid;
  logic [PIN_W-1:0] uio_in;
  logic [PIN_W-1:0] uio_out;
  logic [PIN_W-1:0] uio_oe;

  modport master (
    output ena, req, dir, len0, len1, wdata0, wdata1, uio_in,
    input  gnt, last, rdata, rvalid, uio_out, uio_oe
  );

  modport slave (
    input  ena, req, dir, len0, len1, wdata0, wdata1, uio_in,
    output gnt, last, rdata, rvalid, uio_out, uio_oe
  );

endinterface

// File: rtl/uio_arb_rr.sv
// Two-way round-robin picker: one-hot winner from req, pointer favours the last loser.
// Latency: winner is combinational from req; pointer updates on the clock edge where take=1.
// Backpressure: none; take is asserted only when the caller accepts the winner.
// Ports: clk, rst (async active-high), req[1:0], take, win[1:0] one-hot (0 when no req).
module uio_arb_rr (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       take,
  output logic [1:0] win
);

  // ptr names the requester that wins when both are asking.
  logic ptr;

  always_comb begin
    win = 2'b00;
    case (req)
      2'b01:   win = 2'b01;
      2'b10:   win = 2'b10;
      2'b11:   win = ptr ? 2'b10 : 2'b01;
      default: win = 2'b00;
    endcase
  end

  // Hand priority to the requester that did not win, even when it was not asking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= 1'b0;
    end else if (take && (win != 2'b00)) begin
      ptr <= win[0];
    end
  end

endmodule

// File: rtl/uio_bus_arbiter.sv
// Time-shares the 8 uio pins between two burst requesters with bus-turnaround insertion.
// Latency: gnt 1 cycle after req is sampled in IDLE (+TURNAROUND idle cycles on a turnaround);
//          rdata/rvalid trail each sampled beat by 1 cycle.
// Backpressure: ena=0 holds off new grants; a granted burst always runs len+1 beats.
// Ports: clk, rst (async active-high), bus (slave modport: req/dir/len/wdata in,
//        gnt/last/rdata/rvalid out, uio_in/uio_out/uio_oe pin side).
module uio_bus_arbiter
  import uio_arb_pkg::*;
#(
  parameter int TURNAROUND = 1  // idle cycles inserted on a turnaround, must be >= 1
) (
  input logic              clk,
  input logic              rst,
  uio_bus_arbiter_if.slave bus
);

  localparam int TC_W = $clog2(TURNAROUND + 1);

  arb_state_t       state;
  logic             owner;
  logic             xdir;
  logic [LEN_W-1:0] cnt;       // beats remaining after the current one
  logic [TC_W-1:0]  tcnt;      // turnaround cycles remaining after the current one
  logic             last_dir;
  logic             last_owner;

  logic [1:0]       gnt_q;
  logic             last_q;
  logic             oe_q;
  logic [PIN_W-1:0] rdata_q;
  logic [1:0]       rvalid_q;

  logic [1:0]       win;
  logic             win_idx;
  logic             win_dir;
  logic [LEN_W-1:0] win_len;
  logic             take;
  logic             need_turn;

  assign take    = (state == IDLE) && bus.ena && (win != 2'b00);
  assign win_idx = win[1];
  assign win_dir = bus.dir[win_idx];
  assign win_len = win_idx ? bus.len1 : bus.len0;

  // A direction change always needs a gap; a different driver after a drive burst
  // also needs one so two owners never drive the pins in adjacent cycles.
  assign need_turn = (win_dir != last_dir) ||
                     ((last_dir == DIR_OUT) && (win_idx != last_owner));

  uio_arb_rr u_rr (
    .clk  (clk),
    .rst  (rst),
    .req  (bus.req),
    .take (take),
    .win  (win)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= 1'b0;
      xdir       <= DIR_IN;
      cnt        <= '0;
      tcnt       <= '0;
      last_dir   <= DIR_IN;
      last_owner <= 1'b0;
      gnt_q      <= 2'b00;
      last_q     <= 1'b0;
      oe_q       <= 1'b0;
      rdata_q    <= '0;
      rvalid_q   <= 2'b00;
    end else begin
      rvalid_q <= 2'b00;
      case (state)
        IDLE: begin
          if (take) begin
            owner <= win_idx;
            xdir  <= win_dir;
            cnt   <= win_len;
            if (need_turn) begin
              state <= TURN;
              tcnt  <= TC_W'(TURNAROUND - 1);
            end else begin
              state  <= XFER;
              gnt_q  <= onehot2(win_idx);
              last_q <= (win_len == '0);
              oe_q   <= win_dir;
            end
          end
        end

        TURN: begin
          if (tcnt == '0) begin
            state  <= XFER;
            gnt_q  <= onehot2(owner);
            last_q <= (cnt == '0);
            oe_q   <= xdir;
          end else begin
            tcnt <= tcnt - TC_W'(1);
          end
        end

        XFER: begin
          // Sampled beats are captured at the end of the beat, so the final
          // rvalid lands in the IDLE bubble that follows.
          if (xdir == DIR_IN) begin
            rdata_q  <= bus.uio_in;
            rvalid_q <= onehot2(owner);
          end
          if (cnt == '0) begin
            state      <= IDLE;
            gnt_q      <= 2'b00;
            last_q     <= 1'b0;
            oe_q       <= 1'b0;
            last_dir   <= xdir;
            last_owner <= owner;
          end else begin
            cnt    <= cnt - LEN_W'(1);
            last_q <= (cnt == LEN_W'(1));
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gnt    = gnt_q;
  assign bus.last   = last_q;
  assign bus.uio_oe = {PIN_W{oe_q}};
  assign bus.rdata  = rdata_q;
  assign bus.rvalid = rvalid_q;

  // Drive data goes straight from the owner's wdata to the pins in the same cycle;
  // the state/xdir gate forces the bus to zero outside a drive burst and on reset.
  assign bus.uio_out = ((state == XFER) && (xdir == DIR_OUT)) ?
                       (owner ? bus.wdata1 : bus.wdata0) : '0;

endmodule

// File: tb/tb_uio_bus_arbiter.sv
// Directed bench for uio_bus_arbiter: requester agents, burst scoreboard, rdata scoreboard.
// Expected bursts (owner, dir, len, data pattern, idle gap before grant) are queued when requested.
// Each cycle: monitor at negedge compares DUT outputs, agents drive at posedge+1.
module tb_uio_bus_arbiter;
  import uio_arb_pkg::*;

  localparam int TA = 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uio_bus_arbiter_if bus ();

  uio_bus_arbiter #(.TURNAROUND(TA)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    bit         who;
    bit         dir;
    logic [3:0] len;
    logic [7:0] base;
    logic [7:0] step;
    int         gap;   // gnt-low cycles expected right before the first beat
  } burst_t;

  typedef struct {
    bit         who;
    logic [7:0] data;
  } rd_t;

  burst_t rq0[$];
  burst_t rq1[$];
  burst_t expq[$];
  rd_t    rdq[$];

  int n_pass = 0;
  int n_chk  = 0;
  int n_fail = 0;

  burst_t   cur;
  bit       in_burst = 1'b0;
  int       beat = 0;
  int       idle_cnt = 0;
  bit       rv_pend = 1'b0;
  bit [1:0] saw_last = 2'b00;
  int       abi0 = 0;
  int       abi1 = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    assert (obs === exp_v) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  function automatic burst_t mk(input bit who, input bit dir, input logic [3:0] len,
                                input logic [7:0] base, input logic [7:0] step, input int gap);
    burst_t b;
    b.who = who; b.dir = dir; b.len = len; b.base = base; b.step = step; b.gap = gap;
    return b;
  endfunction

  function automatic logic [7:0] beat_data(input burst_t b, input int n);
    return 8'(int'(b.base) + n * int'(b.step));
  endfunction

  // Present the next queued burst of requester `who`, or drop its req.
  task automatic load(input bit who);
    if (who == 1'b0) begin
      if (rq0.size() > 0) begin
        bus.dir[0] = rq0[0].dir; bus.len0 = rq0[0].len; bus.req[0] = 1'b1; abi0 = 0;
      end else bus.req[0] = 1'b0;
    end else begin
      if (rq1.size() > 0) begin
        bus.dir[1] = rq1[0].dir; bus.len1 = rq1[0].len; bus.req[1] = 1'b1; abi1 = 0;
      end else bus.req[1] = 1'b0;
    end
  endtask

  task automatic request(input burst_t b);
    expq.push_back(b);
    if (b.who == 1'b0) begin
      rq0.push_back(b);
      if (!bus.req[0]) begin load(1'b0); idle_cnt = 0; end
    end else begin
      rq1.push_back(b);
      if (!bus.req[1]) begin load(1'b1); idle_cnt = 0; end
    end
  endtask

  // Requester side, run just after the rising edge.
  task automatic agent();
    rd_t r;
    logic [7:0] v;
    if (saw_last[0]) begin void'(rq0.pop_front()); load(1'b0); end
    if (saw_last[1]) begin void'(rq1.pop_front()); load(1'b1); end
    saw_last = 2'b00;
    bus.wdata0 = 8'($urandom);
    bus.wdata1 = 8'($urandom);
    bus.uio_in = 8'($urandom);
    if (bus.gnt[0] && rq0.size() > 0) begin
      v = beat_data(rq0[0], abi0); abi0++;
      if (rq0[0].dir == DIR_OUT) bus.wdata0 = v;
      else begin bus.uio_in = v; r.who = 1'b0; r.data = v; rdq.push_back(r); end
    end
    if (bus.gnt[1] && rq1.size() > 0) begin
      v = beat_data(rq1[0], abi1); abi1++;
      if (rq1[0].dir == DIR_OUT) bus.wdata1 = v;
      else begin bus.uio_in = v; r.who = 1'b1; r.data = v; rdq.push_back(r); end
    end
  endtask

  // Output checks, run at the falling edge.
  task automatic monitor();
    rd_t r;
    if (rv_pend) begin
      chk("rd_expected", 32'(rdq.size() > 0), 32'd1);
      if (rdq.size() > 0) begin
        r = rdq.pop_front();
        chk("rvalid", 32'(bus.rvalid), r.who ? 32'd2 : 32'd1);
        chk("rdata", 32'(bus.rdata), 32'(r.data));
      end
    end else begin
      chk("rvalid_quiet", 32'(bus.rvalid), 32'd0);
    end
    rv_pend = 1'b0;
    saw_last = bus.gnt & {2{bus.last}};
    if (bus.gnt != 2'b00) begin
      if (!in_burst) begin
        chk("grant_expected", 32'(expq.size() > 0), 32'd1);
        if (expq.size() > 0) begin
          cur = expq.pop_front();
          in_burst = 1'b1;
          beat = 0;
          chk("grant_gap", 32'(idle_cnt), 32'(cur.gap));
        end
      end
      if (in_burst) begin
        chk("gnt", 32'(bus.gnt), cur.who ? 32'd2 : 32'd1);
        chk("last", 32'(bus.last), 32'(beat == int'(cur.len)));
        chk("uio_oe", 32'(bus.uio_oe), (cur.dir == DIR_OUT) ? 32'hFF : 32'h00);
        chk("uio_out", 32'(bus.uio_out), (cur.dir == DIR_OUT) ? 32'(beat_data(cur, beat)) : 32'h00);
        if (cur.dir == DIR_IN) rv_pend = 1'b1;
        if (beat == int'(cur.len)) in_burst = 1'b0;
        beat++;
      end
      idle_cnt = 0;
    end else begin
      chk("gnt_held", 32'(in_burst), 32'd0);
      in_burst = 1'b0;
      idle_cnt++;
      chk("idle_oe", 32'(bus.uio_oe), 32'h00);
      chk("idle_out", 32'(bus.uio_out), 32'h00);
      chk("idle_last", 32'(bus.last), 32'd0);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    agent();
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while ((expq.size() > 0 || in_burst || rv_pend) && n < budget) begin
      tick();
      n++;
    end
    chk(tag, 32'(expq.size() == 0 && !in_burst && !rv_pend), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1;
    bus.ena = 1'b1; bus.req = 2'b00; bus.dir = 2'b00;
    bus.len0 = 4'd0; bus.len1 = 4'd0;
    bus.wdata0 = 8'h00; bus.wdata1 = 8'h00; bus.uio_in = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt", 32'(bus.gnt), 32'd0);
    chk("rst_last", 32'(bus.last), 32'd0);
    chk("rst_rdata", 32'(bus.rdata), 32'd0);
    chk("rst_rvalid", 32'(bus.rvalid), 32'd0);
    chk("rst_uio_out", 32'(bus.uio_out), 32'd0);
    chk("rst_uio_oe", 32'(bus.uio_oe), 32'd0);
    rst = 1'b0;

    // First read after reset: no turnaround, A1..A4 sampled.
    request(mk(1'b0, DIR_IN, 4'd3, 8'hA1, 8'h01, 1));
    drain("read_done", 40);

    // First drive: direction change -> one TURN cycle; 5A then C3.
    request(mk(1'b1, DIR_OUT, 4'd1, 8'h5A, 8'h69, 1 + TA));
    drain("drive_done", 40);

    // Contention, pointer at 0: requester 0 first, then IDLE + TURN, requester 1.
    request(mk(1'b0, DIR_OUT, 4'd0, 8'h11, 8'h00, 1 + TA));
    request(mk(1'b1, DIR_OUT, 4'd0, 8'h22, 8'h00, 1 + TA));
    drain("contend1_done", 40);

    // Same owner back-to-back drives: the second needs only the IDLE bubble.
    request(mk(1'b0, DIR_OUT, 4'd2, 8'h40, 8'h07, 1 + TA));
    request(mk(1'b0, DIR_OUT, 4'd1, 8'h50, 8'h09, 1));
    drain("b2b_done", 40);

    // Contention again, pointer now at 1: requester 1 first.
    request(mk(1'b1, DIR_OUT, 4'd0, 8'h66, 8'h00, 1 + TA));
    request(mk(1'b0, DIR_OUT, 4'd0, 8'h77, 8'h00, 1 + TA));
    drain("contend2_done", 40);

    // ena gating: no grant while low, grant at the next edge once high,
    // dropping ena mid-burst still gives all 8 beats.
    bus.ena = 1'b0;
    request(mk(1'b0, DIR_OUT, 4'd7, 8'h80, 8'h03, 1));
    repeat (4) tick();
    chk("ena_blk_gnt", 32'(bus.gnt), 32'd0);
    chk("ena_blk_pending", 32'(expq.size()), 32'd1);
    bus.ena = 1'b1;
    idle_cnt = 0;
    repeat (3) tick();
    chk("ena_mid_burst", 32'(in_burst), 32'd1);
    bus.ena = 1'b0;
    drain("ena_burst_done", 40);
    bus.ena = 1'b1;

    // Reset during the third beat of a drive burst.
    request(mk(1'b0, DIR_OUT, 4'd7, 8'h30, 8'h11, 1));
    n = 0;
    while (!(in_burst && beat == 2) && n < 20) begin
      tick();
      n++;
    end
    chk("rst_reach_beat3", 32'(in_burst && beat == 2), 32'd1);
    chk("pre_rst_oe", 32'(bus.uio_oe), 32'hFF);
    #1 rst = 1'b1;
    #1;
    chk("midrst_gnt", 32'(bus.gnt), 32'd0);
    chk("midrst_uio_oe", 32'(bus.uio_oe), 32'd0);
    chk("midrst_uio_out", 32'(bus.uio_out), 32'd0);
    chk("midrst_last", 32'(bus.last), 32'd0);
    chk("midrst_rdata", 32'(bus.rdata), 32'd0);
    expq.delete(); rq0.delete(); rq1.delete(); rdq.delete();
    in_burst = 1'b0; rv_pend = 1'b0; saw_last = 2'b00;
    bus.req = 2'b00;
    tick();
    tick();
    rst = 1'b0;

    // After reset last_dir is sample again, so the first drive needs a TURN.
    request(mk(1'b0, DIR_OUT, 4'd0, 8'h9C, 8'h00, 1 + TA));
    drain("post_rst_drive", 40);

    // Maximum-length sample burst by requester 1 after a drive: 16 beats.
    request(mk(1'b1, DIR_IN, 4'd15, 8'h10, 8'h03, 1 + TA));
    drain("max_read_done", 60);

    tick();
    chk("rd_queue_empty", 32'(rdq.size()), 32'd0);
    chk("grant_queue_empty", 32'(expq.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
